// File: rtl/gpu_pkg.sv
// Shared GPU core types: core/LSU state encodings and the fetcher handshake constant.
// Used by the scheduler, ALU, LSUs and decoder.
package gpu_pkg;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_t;

    typedef enum logic [1:0] {
        LSU_IDLE       = 2'b00,
        LSU_REQUESTING = 2'b01,
        LSU_WAITING    = 2'b10,
        LSU_DONE       = 2'b11
    } lsu_state_t;

    localparam logic [2:0] FETCHER_FETCHED = 3'b010;

    // A lane holds the core in WAIT only while its access is outstanding.
    function automatic logic lsu_is_busy(input lsu_state_t s);
        return (s == LSU_REQUESTING) || (s == LSU_WAITING);
    endfunction

endpackage

// File: rtl/lsu_busy_detect.sv
// Reduces per-lane LSU states to a single busy flag over the active lanes.
// thread_count of 0 counts as one lane; values above THREADS are clamped.
module lsu_busy_detect
    import gpu_pkg::*;
#(
    parameter int unsigned THREADS = 4
) (
    input  logic [THREADS*2-1:0]      lsu_state,
    input  logic [$clog2(THREADS):0]  thread_count,
    output logic                      lane_busy_c
);

    localparam int unsigned TC_W = $clog2(THREADS) + 1;

    logic [TC_W-1:0] active_lanes;

    always_comb begin
        if (thread_count == '0) begin
            active_lanes = TC_W'(1);
        end else if (thread_count > TC_W'(THREADS)) begin
            active_lanes = TC_W'(THREADS);
        end else begin
            active_lanes = thread_count;
        end
    end

    always_comb begin
        lane_busy_c = 1'b0;
        for (int unsigned i = 0; i < THREADS; i++) begin
            if ((TC_W'(i) < active_lanes) && lsu_is_busy(lsu_state_t'(lsu_state[2*i +: 2]))) begin
                lane_busy_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/core_scheduler.sv
// Per-core instruction sequencer: FETCH/DECODE/REQUEST/WAIT/EXECUTE/UPDATE, PC advance, RET -> DONE.
// Optional WAIT watchdog enabled by SCHED_WAIT_TIMEOUT_EN.
module core_scheduler
    import gpu_pkg::*;
#(
    parameter int unsigned THREADS      = 4,
    parameter int unsigned PC_BITS      = 8,
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [$clog2(THREADS):0]      thread_count,
    input  logic [2:0]                    fetcher_state,
    input  logic [THREADS*2-1:0]          lsu_state,
    input  logic                          decoded_ret,
    input  logic [THREADS*PC_BITS-1:0]    next_pc,
    output logic [2:0]                    core_state,
    output logic [PC_BITS-1:0]            current_pc,
    output logic                          done,
    output logic                          error
);

    core_state_t         state_q, state_d;
    logic [PC_BITS-1:0]  pc_q, pc_d;
    logic                done_q, done_d;
    logic                wait_first_q;
    logic                lane_busy_c;
    logic                timeout_c;

    // Only lane 0 supplies the shared PC; the other lanes' next_pc are ignored.
    logic unused_next_pc;
    assign unused_next_pc = ^next_pc[THREADS*PC_BITS-1:PC_BITS];

    lsu_busy_detect #(
        .THREADS      (THREADS)
    ) u_busy (
        .lsu_state    (lsu_state),
        .thread_count (thread_count),
        .lane_busy_c  (lane_busy_c)
    );

`ifdef SCHED_WAIT_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(WAIT_TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic             error_q;

    // Counter reads 0 in the first WAIT cycle, so the Nth WAIT cycle sees N-1.
    assign timeout_c = lane_busy_c && (wait_cnt_q == CNT_W'(WAIT_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= '0;
            error_q    <= 1'b0;
        end else begin
            wait_cnt_q <= (state_q == CORE_WAIT) ? wait_cnt_q + CNT_W'(1) : '0;
            if ((state_q == CORE_WAIT) && timeout_c) begin
                error_q <= 1'b1;
            end else if ((state_q == CORE_DONE) && !start) begin
                error_q <= 1'b0;
            end
        end
    end

    assign error = error_q;
`else
    localparam int unsigned unused_wait_timeout = WAIT_TIMEOUT;

    assign timeout_c = 1'b0;
    assign error     = 1'b0;
`endif

    // Next-state and PC/done update.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        done_d  = done_q;
        case (state_q)
            CORE_IDLE: begin
                if (start) state_d = CORE_FETCH;
            end
            CORE_FETCH: begin
                if (fetcher_state == FETCHER_FETCHED) state_d = CORE_DECODE;
            end
            CORE_DECODE:  state_d = CORE_REQUEST;
            CORE_REQUEST: state_d = CORE_WAIT;
            CORE_WAIT: begin
                // First WAIT cycle always holds so the LSUs can leave IDLE.
                if (!wait_first_q && !lane_busy_c) begin
                    state_d = CORE_EXECUTE;
                end else if (timeout_c) begin
                    state_d = CORE_DONE;
                    done_d  = 1'b1;
                end
            end
            CORE_EXECUTE: state_d = CORE_UPDATE;
            CORE_UPDATE: begin
                if (decoded_ret) begin
                    state_d = CORE_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = CORE_FETCH;
                    pc_d    = next_pc[PC_BITS-1:0];
                end
            end
            CORE_DONE: begin
                if (!start) begin
                    state_d = CORE_IDLE;
                    done_d  = 1'b0;
                    pc_d    = '0;
                end
            end
            default: state_d = CORE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= CORE_IDLE;
            pc_q         <= '0;
            done_q       <= 1'b0;
            wait_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            done_q       <= done_d;
            wait_first_q <= (state_q == CORE_REQUEST);
        end
    end

    assign core_state = state_q;
    assign current_pc = pc_q;
    assign done       = done_q;

endmodule

// File: tb/tb_core_scheduler.sv
// Scoreboard bench for core_scheduler: expected per-cycle state/pc/done/error are queued
// from a small sequencing model and compared on the falling edge.
module tb_core_scheduler;

    localparam int unsigned THREADS      = 4;
    localparam int unsigned PC_BITS      = 8;
    localparam int unsigned WAIT_TIMEOUT = 8;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_REQUEST = 3'd3,
                           S_WAIT = 3'd4, S_EXECUTE = 3'd5, S_UPDATE = 3'd6, S_DONE = 3'd7;
    localparam logic [2:0] FETCHED = 3'b010;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       start;
    logic [2:0]                 thread_count;
    logic [2:0]                 fetcher_state;
    logic [THREADS*2-1:0]       lsu_state;
    logic                       decoded_ret;
    logic [THREADS*PC_BITS-1:0] next_pc;
    logic [2:0]                 core_state;
    logic [PC_BITS-1:0]         current_pc;
    logic                       done;
    logic                       error;

    int checks   = 0;
    int failures = 0;

    logic [2:0]         q_state[$];
    logic [PC_BITS-1:0] q_pc[$];
    logic               q_done[$];
    logic               q_err[$];
    logic [PC_BITS-1:0] model_pc = '0;

    always #5 clk = ~clk;

    core_scheduler #(
        .THREADS      (THREADS),
        .PC_BITS      (PC_BITS),
        .WAIT_TIMEOUT (WAIT_TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .thread_count  (thread_count),
        .fetcher_state (fetcher_state),
        .lsu_state     (lsu_state),
        .decoded_ret   (decoded_ret),
        .next_pc       (next_pc),
        .core_state    (core_state),
        .current_pc    (current_pc),
        .done          (done),
        .error         (error)
    );

    function automatic void push_exp(input logic [2:0] s, input logic [PC_BITS-1:0] p,
                                     input logic d, input logic e);
        q_state.push_back(s);
        q_pc.push_back(p);
        q_done.push_back(d);
        q_err.push_back(e);
    endfunction

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; thread_count = 3'd4; fetcher_state = FETCHED;
        lsu_state = '0; decoded_ret = 1'b0; next_pc = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (core_state !== S_IDLE || current_pc !== '0 || done !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL reset: got state=%0d pc=%0h done=%b error=%b, want 0 0 0 0",
                     core_state, current_pc, done, error);
        end
        reset = 1'b1;
    endtask

    // One instruction starting in FETCH; lane `lane` stays busy for the first `busy` WAIT cycles.
    task automatic test_instruction(input string name, input int tc, input int lane, input int busy,
                                    input logic [PC_BITS-1:0] npc, input int fdelay);
        int eff, nw, fcnt, wcnt, k;
        logic [2:0] es;
        logic [PC_BITS-1:0] ep;
        logic ed, ee;
        eff = (tc == 0) ? 1 : ((tc > THREADS) ? THREADS : tc);
        nw  = (lane < eff && busy > 0) ? ((busy + 1 > 2) ? busy + 1 : 2) : 2;
        for (int i = 0; i < fdelay; i++) push_exp(S_FETCH, model_pc, 1'b0, 1'b0);
        push_exp(S_DECODE, model_pc, 1'b0, 1'b0);
        push_exp(S_REQUEST, model_pc, 1'b0, 1'b0);
        for (int i = 0; i < nw; i++) push_exp(S_WAIT, model_pc, 1'b0, 1'b0);
        push_exp(S_EXECUTE, model_pc, 1'b0, 1'b0);
        push_exp(S_UPDATE, model_pc, 1'b0, 1'b0);
        push_exp(S_FETCH, npc, 1'b0, 1'b0);
        thread_count  = 3'(tc);
        next_pc       = {npc ^ 8'h5A, npc ^ 8'hC3, npc ^ 8'h81, npc};
        decoded_ret   = 1'b0;
        lsu_state     = '0;
        fetcher_state = (fdelay > 0) ? 3'b001 : FETCHED;
        fcnt = 0; wcnt = 0; k = 0;
        while (q_state.size() > 0) begin
            @(negedge clk);
            es = q_state.pop_front(); ep = q_pc.pop_front();
            ed = q_done.pop_front();  ee = q_err.pop_front();
            k++;
            checks++;
            if (core_state !== es || current_pc !== ep || done !== ed || error !== ee) begin
                failures++;
                $display("FAIL %s step %0d: got state=%0d pc=%0h done=%b error=%b, want state=%0d pc=%0h done=%b error=%b",
                         name, k, core_state, current_pc, done, error, es, ep, ed, ee);
            end
            if (es == S_FETCH) begin
                fcnt++;
                fetcher_state = (fcnt < fdelay) ? 3'b001 : FETCHED;
            end
            lsu_state = '0;
            if (es == S_WAIT) begin
                wcnt++;
                lsu_state[2*lane +: 2] = (wcnt <= busy) ? 2'b10 : 2'b11;
            end else if (es == S_REQUEST && busy > 0) begin
                lsu_state[2*lane +: 2] = 2'b01;
            end
        end
        model_pc = npc;
    endtask

    // From IDLE: one held cycle with start low, then launch into FETCH.
    task automatic test_launch(input string name);
        logic [2:0] es;
        logic [PC_BITS-1:0] ep;
        logic ed, ee;
        int k;
        start = 1'b0; fetcher_state = FETCHED; lsu_state = '0; decoded_ret = 1'b0;
        push_exp(S_IDLE, '0, 1'b0, 1'b0);
        push_exp(S_FETCH, '0, 1'b0, 1'b0);
        k = 0;
        while (q_state.size() > 0) begin
            @(negedge clk);
            es = q_state.pop_front(); ep = q_pc.pop_front();
            ed = q_done.pop_front();  ee = q_err.pop_front();
            k++;
            checks++;
            if (core_state !== es || current_pc !== ep || done !== ed || error !== ee) begin
                failures++;
                $display("FAIL %s step %0d: got state=%0d pc=%0h done=%b error=%b, want state=%0d pc=%0h done=%b error=%b",
                         name, k, core_state, current_pc, done, error, es, ep, ed, ee);
            end
            start = 1'b1;
        end
        model_pc = '0;
    endtask

    // RET at pc=5: DONE holds pc and done while start stays high, start low returns to IDLE.
    task automatic test_ret_relaunch();
        logic [2:0] es;
        logic [PC_BITS-1:0] ep;
        logic ed, ee;
        int k;
        decoded_ret = 1'b1; lsu_state = '0; fetcher_state = FETCHED; thread_count = 3'd4;
        next_pc = {4{8'h99}};
        push_exp(S_DECODE, model_pc, 1'b0, 1'b0);
        push_exp(S_REQUEST, model_pc, 1'b0, 1'b0);
        push_exp(S_WAIT, model_pc, 1'b0, 1'b0);
        push_exp(S_WAIT, model_pc, 1'b0, 1'b0);
        push_exp(S_EXECUTE, model_pc, 1'b0, 1'b0);
        push_exp(S_UPDATE, model_pc, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) push_exp(S_DONE, model_pc, 1'b1, 1'b0);
        push_exp(S_IDLE, '0, 1'b0, 1'b0);
        push_exp(S_IDLE, '0, 1'b0, 1'b0);
        k = 0;
        while (q_state.size() > 0) begin
            @(negedge clk);
            es = q_state.pop_front(); ep = q_pc.pop_front();
            ed = q_done.pop_front();  ee = q_err.pop_front();
            k++;
            checks++;
            if (core_state !== es || current_pc !== ep || done !== ed || error !== ee) begin
                failures++;
                $display("FAIL ret step %0d: got state=%0d pc=%0h done=%b error=%b, want state=%0d pc=%0h done=%b error=%b",
                         k, core_state, current_pc, done, error, es, ep, ed, ee);
            end
            if (k == 9) start = 1'b0;
        end
        decoded_ret = 1'b0;
        model_pc = '0;
    endtask

    // Asynchronous reset while stalled in WAIT must clear state and PC before the next edge.
    task automatic test_reset_mid();
        logic [2:0] es;
        logic [PC_BITS-1:0] ep;
        logic ed, ee;
        int k;
        test_launch("launch_mid");
        test_instruction("pre_reset", 4, 0, 0, 8'h44, 0);
        lsu_state = '0;
        lsu_state[1:0] = 2'b10;
        push_exp(S_DECODE, model_pc, 1'b0, 1'b0);
        push_exp(S_REQUEST, model_pc, 1'b0, 1'b0);
        push_exp(S_WAIT, model_pc, 1'b0, 1'b0);
        k = 0;
        while (q_state.size() > 0) begin
            @(negedge clk);
            es = q_state.pop_front(); ep = q_pc.pop_front();
            ed = q_done.pop_front();  ee = q_err.pop_front();
            k++;
            checks++;
            if (core_state !== es || current_pc !== ep || done !== ed || error !== ee) begin
                failures++;
                $display("FAIL reset_mid step %0d: got state=%0d pc=%0h done=%b error=%b, want state=%0d pc=%0h done=%b error=%b",
                         k, core_state, current_pc, done, error, es, ep, ed, ee);
            end
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (core_state !== S_IDLE || current_pc !== '0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: got state=%0d pc=%0h done=%b, want 0 0 0",
                     core_state, current_pc, done);
        end
        @(negedge clk);
        start = 1'b0; lsu_state = '0;
        reset = 1'b1;
        model_pc = '0;
    endtask

    // Lane 0 never finishes: watchdog ends the block on the 8th WAIT cycle if enabled.
    task automatic test_timeout();
        logic [2:0] es;
        logic [PC_BITS-1:0] ep;
        logic ed, ee;
        int k;
        test_launch("launch_to");
        thread_count = 3'd4; fetcher_state = FETCHED; decoded_ret = 1'b0;
        lsu_state = '0;
        lsu_state[1:0] = 2'b10;
        push_exp(S_DECODE, '0, 1'b0, 1'b0);
        push_exp(S_REQUEST, '0, 1'b0, 1'b0);
`ifdef SCHED_WAIT_TIMEOUT_EN
        for (int i = 0; i < WAIT_TIMEOUT; i++) push_exp(S_WAIT, '0, 1'b0, 1'b0);
        push_exp(S_DONE, '0, 1'b1, 1'b1);
        push_exp(S_DONE, '0, 1'b1, 1'b1);
        push_exp(S_IDLE, '0, 1'b0, 1'b0);
`else
        for (int i = 0; i < 12; i++) push_exp(S_WAIT, '0, 1'b0, 1'b0);
`endif
        k = 0;
        while (q_state.size() > 0) begin
            @(negedge clk);
            es = q_state.pop_front(); ep = q_pc.pop_front();
            ed = q_done.pop_front();  ee = q_err.pop_front();
            k++;
            checks++;
            if (core_state !== es || current_pc !== ep || done !== ed || error !== ee) begin
                failures++;
                $display("FAIL timeout step %0d: got state=%0d pc=%0h done=%b error=%b, want state=%0d pc=%0h done=%b error=%b",
                         k, core_state, current_pc, done, error, es, ep, ed, ee);
            end
            if (es == S_DONE && k == WAIT_TIMEOUT + 4) start = 1'b0;
        end
        reset = 1'b0; start = 1'b0; lsu_state = '0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_launch("launch");
        test_instruction("basic", 4, 0, 0, 8'h01, 0);
        test_instruction("stall", 4, 2, 5, 8'h20, 0);
        test_instruction("fetch_hold", 4, 1, 1, 8'h21, 2);
        test_instruction("masked", 2, 3, 50, 8'h30, 0);
        test_instruction("tc_zero_masked", 0, 1, 50, 8'h31, 0);
        test_instruction("tc_zero_lane0", 0, 0, 3, 8'h32, 0);
        test_instruction("clamp", 7, 3, 3, 8'h33, 0);
        test_instruction("back_to_back", 4, 0, 0, 8'hFF, 0);
        test_instruction("pc_wrap", 4, 0, 0, 8'h00, 0);
        test_instruction("pc5", 4, 0, 0, 8'h05, 0);
        test_ret_relaunch();
        test_reset_mid();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/core_scheduler.md
Name: core_scheduler

Overview:
- Per-core control FSM that generates the 3-bit core_state stepped through by the ALU, LSUs, register files and decoder.
- Sequences FETCH -> DECODE -> REQUEST -> WAIT -> EXECUTE -> UPDATE for each instruction.
- Stalls in WAIT until all active LSU lanes are quiescent.
- Advances the shared PC from lane 0's next_pc and signals done on RET.

Parameters:
- THREADS, 4, lanes per core; lane 0 is always the PC source.
- PC_BITS, 8, program-counter width.
- WAIT_TIMEOUT, 255, maximum cycles in WAIT. Used only with SCHED_WAIT_TIMEOUT_EN.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low; the block is held in reset while reset==0.
- start  in  1  level; launches a block when high in IDLE.
- thread_count  in  $clog2(THREADS)+1  active lanes, 1..THREADS; lanes >= thread_count are ignored.
- fetcher_state  in  3  instruction fetcher state; FETCHED = 3'b010.
- lsu_state  in  THREADS*2  per-lane LSU state, lane i at [2i+1:2i]; IDLE=00, REQUESTING=01, WAITING=10, DONE=11.
- decoded_ret  in  1  the current instruction is RET.
- next_pc  in  THREADS*PC_BITS  per-lane next PC, lane i at [(i+1)*PC_BITS-1 : i*PC_BITS].
- core_state  out  3  IDLE=000, FETCH=001, DECODE=010, REQUEST=011, WAIT=100, EXECUTE=101, UPDATE=110, DONE=111.
- current_pc  out  PC_BITS  PC of the instruction in flight.
- done  out  1  high while in DONE.
- error  out  1  WAIT timeout flag.

Behaviour:
- Reset (asynchronous assert, synchronous release): core_state=IDLE, current_pc=0, done=0, error=0, wait counter=0.
- All outputs are registered; core_state changes only on a rising clk edge.
- IDLE: start==1 -> FETCH. current_pc stays 0.
- FETCH: holds until fetcher_state==FETCHED, then -> DECODE. The minimum is 1 cycle.
- DECODE: 1 cycle -> REQUEST.
- REQUEST: 1 cycle -> WAIT. LSUs sample REQUEST to launch their accesses.
- WAIT: lane_busy = any active lane with lsu_state in {REQUESTING, WAITING}.
  - The first WAIT cycle always stays in WAIT, giving LSUs one cycle to leave IDLE.
  - From the second cycle, !lane_busy -> EXECUTE.
  - Lanes in DONE or IDLE count as not busy.
- EXECUTE: 1 cycle -> UPDATE. This is the state in which the ALU latches its result.
- UPDATE:
  - If decoded_ret==1: -> DONE, done<=1, and current_pc is unchanged.
  - Otherwise: current_pc <= next_pc lane 0, -> FETCH.
- DONE: done held high. start==0 -> IDLE, clearing done and current_pc on the same edge. start held high keeps the FSM in DONE; there is no automatic relaunch.
- Instruction latency without memory stalls is 7 cycles FETCH->FETCH: FETCH 1, DECODE 1, REQUEST 1, WAIT 2, EXECUTE 1, UPDATE 1.
- thread_count==0 is treated as 1. Values > THREADS are clamped to THREADS.
- PC wrap: next_pc is taken verbatim, so all-ones to 0 is legal with no flag.
- start deasserted mid-block is ignored. Only reset aborts a block.
- Reset asserted mid-operation returns the FSM to IDLE immediately, regardless of LSU state.

Optional Feature:
- Macro: SCHED_WAIT_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches WAIT_TIMEOUT while lane_busy is still 1: -> DONE with done<=1 and error<=1.
  - error stays set until reset, or until the DONE -> IDLE transition.
- Undefined: no counter is synthesized, error is tied 0, and WAIT may stall indefinitely.

Decomposition:
- Package gpu_pkg holds:
  - core_state_t enum (3-bit encodings above).
  - lsu_state_t (2-bit) and the fetcher FETCHED constant.
  - Shared with the ALU, LSU and decoder.
- Sub-module lsu_busy_detect: combinational reduction of lsu_state and thread_count to lane_busy, parameterized by THREADS. Everything else is in core_scheduler.

Test Plan:
- Basic sequence:
  - Stimulus: reset low 2 cycles, then high; start=1; thread_count=4; fetcher FETCHED after 1 cycle; all LSU IDLE; next_pc lane0=1; decoded_ret=0.
  - Response: core_state goes 001,010,011,100,100,101,110,001; current_pc=1 after UPDATE.
- Memory stall:
  - Stimulus: lane 2 lsu_state=WAITING for 5 cycles after REQUEST, then DONE.
  - Response: WAIT lasts exactly until the cycle after lane 2 reaches DONE, then EXECUTE.
- Inactive lane masked:
  - Stimulus: thread_count=2, lane 3 stuck WAITING.
  - Response: WAIT exits after 2 cycles.
- RET and relaunch:
  - Stimulus: decoded_ret=1 in UPDATE with current_pc=5.
  - Response: core_state=111, done=1, current_pc stays 5; after start=0, core_state=000, done=0, current_pc=0.
- Reset mid-operation:
  - Stimulus: reset=0 asynchronously during WAIT.
  - Response: core_state=000 and current_pc=0 before the next clk edge.
- Timeout (SCHED_WAIT_TIMEOUT_EN, WAIT_TIMEOUT=8):
  - Stimulus: lane 0 held WAITING.
  - Response: the 8th WAIT cycle -> DONE, done=1, error=1.
  - Without the macro: FSM stays in WAIT, error=0.
